// File: rtl/dcache_pkg.sv
// ============================================================================
//  Module      : dcache_pkg
//  Description : Shared geometry constants and FSM state encoding for the
//                byte-wide direct-mapped data cache.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dcache_pkg;

    localparam int LINES       = 8;
    localparam int BLOCK_BYTES = 4;
    localparam int ADDR_W      = 8;
    localparam int IDX_W       = $clog2(LINES);
    localparam int OFF_W       = $clog2(BLOCK_BYTES);
    localparam int TAG_W       = ADDR_W - IDX_W - OFF_W;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WB_REQ   = 3'd1,
        S_WB_GAP   = 3'd2,
        S_FILL_REQ = 3'd3,
        S_FILL_GAP = 3'd4,
        S_UPDATE   = 3'd5
    } state_e;

endpackage

`default_nettype wire

// File: rtl/dcache_line_array.sv
// ============================================================================
//  Module      : dcache_line_array
//  Description : Valid/dirty/tag/data storage, combinational read port and a
//                synchronous single-byte or whole-line write port.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dcache_line_array
    import dcache_pkg::*;
#(
    parameter int LINES       = 8,
    parameter int BLOCK_BYTES = 4,
    parameter int TAG_W       = 3,
    localparam int IDX_W      = $clog2(LINES),
    localparam int OFF_W      = $clog2(BLOCK_BYTES),
    localparam int LINE_W     = 8 * BLOCK_BYTES
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [IDX_W-1:0]  index_i,
    output logic              valid_o,
    output logic              dirty_o,
    output logic [TAG_W-1:0]  tag_o,
    output logic [LINE_W-1:0] line_o,
    input  logic              byte_we_i,
    input  logic [OFF_W-1:0]  offset_i,
    input  logic [7:0]        byte_i,
    input  logic              line_we_i,
    input  logic [TAG_W-1:0]  line_tag_i,
    input  logic [LINE_W-1:0] line_i
);

    logic [LINES-1:0]  valid_q;
    logic [LINES-1:0]  dirty_q;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [LINE_W-1:0] data_q [LINES];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (line_we_i) begin
            valid_q[index_i] <= 1'b1;
            dirty_q[index_i] <= 1'b0;
        end else if (byte_we_i) begin
            dirty_q[index_i] <= 1'b1;
        end
    end

    // Tags and data are left unreset; valid gates every use of them.
    always_ff @(posedge clock) begin
        if (line_we_i) begin
            tag_q[index_i]  <= line_tag_i;
            data_q[index_i] <= line_i;
        end else if (byte_we_i) begin
            data_q[index_i][{offset_i, 3'b000} +: 8] <= byte_i;
        end
    end

    assign valid_o = valid_q[index_i];
    assign dirty_o = dirty_q[index_i];
    assign tag_o   = tag_q[index_i];
    assign line_o  = data_q[index_i];

endmodule

`default_nettype wire

// File: rtl/dcache_byte_ctrl.sv
// ============================================================================
//  Module      : dcache_byte_ctrl
//  Description : Direct-mapped write-back cache; blocks move as byte beats.
//                Optional macro DCACHE_STATS_EN adds hit/miss counters.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dcache_byte_ctrl
    import dcache_pkg::*;
#(
    parameter int LINES       = 8,
    parameter int BLOCK_BYTES = 4,
    parameter int ADDR_W      = 8,
    localparam int IDX_W      = $clog2(LINES),
    localparam int OFF_W      = $clog2(BLOCK_BYTES),
    localparam int TAG_W      = ADDR_W - IDX_W - OFF_W,
    localparam int LINE_W     = 8 * BLOCK_BYTES
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic [7:0]        cpu_writedata,
    output logic [7:0]        cpu_readdata,
    output logic              cpu_busywait,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [7:0]        mem_writedata,
    input  logic [7:0]        mem_readdata,
    input  logic              mem_busywait
`ifdef DCACHE_STATS_EN
    ,
    output logic [15:0]       hit_count,
    output logic [15:0]       miss_count
`endif
);

    state_e              state_q, state_d;
    logic [OFF_W-1:0]    beat_q, beat_d;
    logic                mem_read_q, mem_read_d;
    logic                mem_write_q, mem_write_d;
    logic [ADDR_W-1:0]   mem_address_q, mem_address_d;
    logic [7:0]          mem_wdata_q, mem_wdata_d;
    logic [LINE_W-1:0]   fill_q;

    logic [TAG_W-1:0]    w_tag;
    logic [IDX_W-1:0]    w_idx;
    logic [OFF_W-1:0]    w_off;
    logic                w_valid, w_dirty, w_req, w_hit, w_last_beat;
    logic [TAG_W-1:0]    w_vtag;
    logic [LINE_W-1:0]   w_line;

    assign w_tag       = cpu_address[ADDR_W-1 -: TAG_W];
    assign w_idx       = cpu_address[OFF_W +: IDX_W];
    assign w_off       = cpu_address[OFF_W-1:0];
    assign w_req       = cpu_read | cpu_write;
    assign w_hit       = w_valid && (w_vtag == w_tag) && w_req;
    assign w_last_beat = (beat_q == OFF_W'(BLOCK_BYTES - 1));

    dcache_line_array #(
        .LINES       (LINES),
        .BLOCK_BYTES (BLOCK_BYTES),
        .TAG_W       (TAG_W)
    ) u_lines (
        .clock       (clock),
        .reset       (reset),
        .index_i     (w_idx),
        .valid_o     (w_valid),
        .dirty_o     (w_dirty),
        .tag_o       (w_vtag),
        .line_o      (w_line),
        .byte_we_i   ((state_q == S_IDLE) && w_hit && cpu_write),
        .offset_i    (w_off),
        .byte_i      (cpu_writedata),
        .line_we_i   (state_q == S_UPDATE),
        .line_tag_i  (w_tag),
        .line_i      (fill_q)
    );

    assign cpu_busywait  = w_req && !((state_q == S_IDLE) && w_hit);
    assign cpu_readdata  = w_hit ? w_line[{w_off, 3'b000} +: 8] : 8'h00;
    assign mem_read      = mem_read_q;
    assign mem_write     = mem_write_q;
    assign mem_address   = mem_address_q;
    assign mem_writedata = mem_wdata_q;

    always_comb begin
        state_d       = state_q;
        beat_d        = beat_q;
        mem_address_d = mem_address_q;
        mem_wdata_d   = mem_wdata_q;
        case (state_q)
            S_IDLE: begin
                if (w_req && !w_hit) begin
                    beat_d  = '0;
                    state_d = (w_valid && w_dirty) ? S_WB_REQ : S_FILL_REQ;
                end
            end
            S_WB_REQ:   if (!mem_busywait) state_d = S_WB_GAP;
            S_WB_GAP: begin
                if (w_last_beat) begin
                    state_d = S_FILL_REQ;
                    beat_d  = '0;
                end else begin
                    state_d = S_WB_REQ;
                    beat_d  = beat_q + 1'b1;
                end
            end
            S_FILL_REQ: if (!mem_busywait) state_d = S_FILL_GAP;
            S_FILL_GAP: begin
                if (w_last_beat) begin
                    state_d = S_UPDATE;
                end else begin
                    state_d = S_FILL_REQ;
                    beat_d  = beat_q + 1'b1;
                end
            end
            S_UPDATE:   state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase

        // Memory requests are registered, so they are derived from the next state.
        mem_write_d = (state_d == S_WB_REQ);
        mem_read_d  = (state_d == S_FILL_REQ);
        if (mem_write_d) begin
            mem_address_d = {w_vtag, w_idx, beat_d};
            mem_wdata_d   = w_line[{beat_d, 3'b000} +: 8];
        end else if (mem_read_d) begin
            mem_address_d = {w_tag, w_idx, beat_d};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            beat_q        <= '0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_address_q <= '0;
            mem_wdata_q   <= 8'h00;
        end else begin
            state_q       <= state_d;
            beat_q        <= beat_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
            mem_address_q <= mem_address_d;
            mem_wdata_q   <= mem_wdata_d;
        end
    end

    always_ff @(posedge clock) begin
        if ((state_q == S_FILL_REQ) && !mem_busywait) begin
            fill_q[{beat_q, 3'b000} +: 8] <= mem_readdata;
        end
    end

`ifdef DCACHE_STATS_EN
    logic [15:0] hit_count_q, miss_count_q;
    logic        miss_pend_q;

    // The hit that retires a refilled request belongs to its miss, not a new hit.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hit_count_q  <= 16'h0000;
            miss_count_q <= 16'h0000;
            miss_pend_q  <= 1'b0;
        end else if (state_q == S_IDLE && w_req) begin
            if (!w_hit) begin
                miss_pend_q <= 1'b1;
                if (miss_count_q != 16'hFFFF) miss_count_q <= miss_count_q + 16'd1;
            end else if (miss_pend_q) begin
                miss_pend_q <= 1'b0;
            end else if (hit_count_q != 16'hFFFF) begin
                hit_count_q <= hit_count_q + 16'd1;
            end
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dcache_byte_ctrl.sv
// ============================================================================
//  Module      : tb_dcache_byte_ctrl
//  Description : Self-checking bench: latency-programmable byte memory plus a
//                line-level cache model predicting beats, data and stalls.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dcache_byte_ctrl;

    localparam int LAT       = 2;
    localparam int STALL_MAX = 400;

    logic       clock = 1'b0;
    logic       reset;
    logic       cpu_read, cpu_write;
    logic [7:0] cpu_address, cpu_writedata;
    logic [7:0] cpu_readdata;
    logic       cpu_busywait;
    logic       mem_read, mem_write;
    logic [7:0] mem_address, mem_writedata, mem_readdata;
    logic       mem_busywait;
`ifdef DCACHE_STATS_EN
    logic [15:0] hit_count, miss_count;
`endif

    dcache_byte_ctrl dut (
        .clock         (clock),
        .reset         (reset),
        .cpu_read      (cpu_read),
        .cpu_write     (cpu_write),
        .cpu_address   (cpu_address),
        .cpu_writedata (cpu_writedata),
        .cpu_readdata  (cpu_readdata),
        .cpu_busywait  (cpu_busywait),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_address   (mem_address),
        .mem_writedata (mem_writedata),
        .mem_readdata  (mem_readdata),
        .mem_busywait  (mem_busywait)
`ifdef DCACHE_STATS_EN
        ,
        .hit_count     (hit_count),
        .miss_count    (miss_count)
`endif
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Byte memory: busy for LAT cycles of each request, then completes.
    logic [7:0] mem_store [256];
    logic [7:0] ref_mem   [256];
    int         lat_cnt;

    assign mem_readdata = mem_store[mem_address];
    assign mem_busywait = (mem_read || mem_write) && (lat_cnt < LAT);

    always @(posedge clock or posedge reset) begin
        if (reset)                      lat_cnt <= 0;
        else if (!(mem_read || mem_write)) lat_cnt <= 0;
        else                            lat_cnt <= lat_cnt + 1;
    end

    always @(posedge clock) begin
        if (!reset && mem_write && !mem_busywait) mem_store[mem_address] <= mem_writedata;
    end

    // Line-level cache model and expected memory transactions.
    typedef struct {
        bit         wr;
        logic [7:0] addr;
        logic [7:0] data;
    } txn_t;

    txn_t       exp_q [$];
    logic [7:0] mv, md;
    logic [2:0] mt    [8];
    logic [7:0] mdata [8][4];

    function automatic void model_access(input bit wr, input logic [7:0] a, input logic [7:0] d,
                                         output bit hit, output bit wb);
        logic [2:0] t, i;
        logic [1:0] o;
        logic [7:0] ad;
        t = a[7:5]; i = a[4:2]; o = a[1:0];
        hit = mv[i] && (mt[i] == t);
        wb  = 1'b0;
        if (!hit) begin
            wb = md[i];
            if (wb) begin
                for (int b = 0; b < 4; b++) begin
                    ad = {mt[i], i, b[1:0]};
                    exp_q.push_back('{1'b1, ad, mdata[i][b]});
                    ref_mem[ad] = mdata[i][b];
                end
            end
            for (int b = 0; b < 4; b++) begin
                ad = {t, i, b[1:0]};
                exp_q.push_back('{1'b0, ad, ref_mem[ad]});
                mdata[i][b] = ref_mem[ad];
            end
            mv[i] = 1'b1; md[i] = 1'b0; mt[i] = t;
        end
        if (wr) begin
            mdata[i][o] = d;
            md[i] = 1'b1;
        end
    endfunction

    // Compare process: memory beats, inter-beat gap, exclusivity, load data.
    bit gap_needed = 1'b0;
    always @(posedge clock) begin
        if (reset) begin
            gap_needed = 1'b0;
        end else begin
            if (gap_needed) chk("beat_gap", int'(mem_read || mem_write), 0);
            gap_needed = (mem_read || mem_write) && !mem_busywait;
            if (gap_needed) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_mem_txn", int'(mem_address), -1);
                end else begin
                    txn_t e;
                    e = exp_q.pop_front();
                    chk("txn_kind", int'(mem_write), int'(e.wr));
                    chk("txn_addr", int'(mem_address), int'(e.addr));
                    if (e.wr) chk("txn_wdata", int'(mem_writedata), int'(e.data));
                end
            end
        end
    end

    always @(negedge clock) begin
        if (!reset) begin
            chk("rd_wr_exclusive", int'(mem_read && mem_write), 0);
            if (cpu_read && !cpu_write && !cpu_busywait)
                chk("cpu_readdata", int'(cpu_readdata),
                    int'(mdata[cpu_address[4:2]][cpu_address[1:0]]));
            if (!cpu_read && !cpu_write)
                chk("idle_outputs", int'({cpu_busywait, cpu_readdata}), 0);
        end
    end

    task automatic op(input bit wr, input logic [7:0] a, input logic [7:0] d,
                      output logic [7:0] rd);
        bit hit, wb;
        int stall;
        model_access(wr, a, d, hit, wb);
        @(posedge clock); #1;
        cpu_read = !wr; cpu_write = wr; cpu_address = a; cpu_writedata = d;
        stall = 0;
        @(negedge clock);
        while (cpu_busywait && stall < STALL_MAX) begin
            stall++;
            @(negedge clock);
        end
        rd = cpu_readdata;
        // Each beat: LAT busy cycles + completing cycle + gap; plus IDLE and UPDATE.
        chk("stall_cycles", stall, hit ? 0 : (2 + 4 * (LAT + 2) * (wb ? 2 : 1)));
        chk("txns_drained", exp_q.size(), 0);
        @(posedge clock); #1;
        cpu_read = 1'b0; cpu_write = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_mem_read"},  int'(mem_read), 0);
        chk({tag, "_mem_write"}, int'(mem_write), 0);
        chk({tag, "_mem_addr"},  int'(mem_address), 0);
        chk({tag, "_mem_wdata"}, int'(mem_writedata), 0);
        chk({tag, "_busywait"},  int'(cpu_busywait), 0);
        chk({tag, "_readdata"},  int'(cpu_readdata), 0);
    endtask

    initial begin
        logic [7:0] rd;
        bit         h, w;
        int         n;
        for (int i = 0; i < 256; i++) begin
            mem_store[i] = 8'(i) ^ 8'h5A;
            ref_mem[i]   = 8'(i) ^ 8'h5A;
        end
        mv = '0; md = '0;
        reset = 1'b1;
        cpu_read = 1'b0; cpu_write = 1'b0; cpu_address = 8'h00; cpu_writedata = 8'h00;
        repeat (3) @(posedge clock);
        #1;
        check_reset_state("reset");
        reset = 1'b0;

        op(1'b0, 8'h25, 8'h00, rd);  chk("first_miss_data", int'(rd), 8'h7F);
        op(1'b0, 8'h26, 8'h00, rd);  chk("hit_data", int'(rd), 8'h7C);
        op(1'b1, 8'h24, 8'hAB, rd);
        op(1'b0, 8'hA4, 8'h00, rd);  chk("evict_fill_data", int'(rd), 8'hFE);
        chk("writeback_byte0", int'(mem_store[8'h24]), 8'hAB);
        chk("writeback_byte1", int'(mem_store[8'h25]), 8'h7F);
`ifdef DCACHE_STATS_EN
        chk("hit_count", int'(hit_count), 2);
        chk("miss_count", int'(miss_count), 2);
`endif

        // Abandon a refill at its third beat with an asynchronous reset.
        model_access(1'b0, 8'h25, 8'h00, h, w);
        @(posedge clock); #1;
        cpu_read = 1'b1; cpu_address = 8'h25;
        n = 0;
        while (!(mem_read && mem_address == 8'h26) && n < STALL_MAX) begin
            @(negedge clock);
            n++;
        end
        chk("reached_fill_beat2", int'(mem_read && mem_address == 8'h26), 1);
        #2 reset = 1'b1;
        #1;
        cpu_read = 1'b0;
        exp_q.delete();
        mv = '0; md = '0;
        #1;
        check_reset_state("midfill_reset");
`ifdef DCACHE_STATS_EN
        chk("hit_count_reset", int'(hit_count), 0);
        chk("miss_count_reset", int'(miss_count), 0);
`endif
        @(posedge clock); #3;
        reset = 1'b0;

        op(1'b0, 8'h25, 8'h00, rd);  chk("re_miss_data", int'(rd), 8'h7F);
        op(1'b1, 8'h31, 8'h3C, rd);
        op(1'b0, 8'h31, 8'h00, rd);  chk("alloc_write_data", int'(rd), 8'h3C);
        op(1'b0, 8'h51, 8'h00, rd);  chk("dirty_evict_data", int'(rd), 8'h0B);
        op(1'b0, 8'h31, 8'h00, rd);  chk("refetch_written", int'(rd), 8'h3C);
        op(1'b1, 8'hFF, 8'hFF, rd);
        op(1'b0, 8'hFC, 8'h00, rd);  chk("top_line_data", int'(rd), 8'hA6);
        op(1'b0, 8'hFF, 8'h00, rd);  chk("top_byte_data", int'(rd), 8'hFF);
        op(1'b0, 8'h1F, 8'h00, rd);  chk("evict_top_line", int'(rd), 8'h45);
        chk("top_writeback", int'(mem_store[8'hFF]), 8'hFF);

        repeat (4) @(posedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/dcache_byte_ctrl.md
Name: dcache_byte_ctrl

Overview:
- Direct-mapped, write-back, write-allocate data cache between the CPU load/store path and the byte-wide data memory.
- Acts as responder to the CPU and as initiator on the memory read/write/busywait interface.
- Moves each 4-byte block as 4 single-byte memory transactions.
- Hits complete with no stall; misses stall the CPU through cpu_busywait until the block is refilled.

Parameters:
- LINES, 8, number of cache lines; index width is log2(LINES).
- BLOCK_BYTES, 4, bytes per line; offset width is log2(BLOCK_BYTES).
- ADDR_W, 8, byte address width; tag width is ADDR_W - index width - offset width (3 at defaults).

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high.
- cpu_read  in  1  CPU load request.
- cpu_write  in  1  CPU store request.
- cpu_address  in  ADDR_W  CPU byte address.
- cpu_writedata  in  8  store data.
- cpu_readdata  out  8  load data.
- cpu_busywait  out  1  CPU stall; high while a request is unresolved.
- mem_read  out  1  memory read request, registered.
- mem_write  out  1  memory write request, registered.
- mem_address  out  ADDR_W  memory byte address, registered.
- mem_writedata  out  8  memory write data, registered.
- mem_readdata  in  8  memory read data.
- mem_busywait  in  1  memory busy.

Behaviour:
- Address split: tag = cpu_address[7:5], index = [4:2], offset = [1:0].
- Per line state: valid, dirty, tag, 4 data bytes.
- Hit = valid[index] && tag match && (cpu_read || cpu_write).
- cpu_busywait: combinational; 0 when there is no request or on a hit in IDLE; 1 otherwise.
- Read hit: cpu_readdata = selected byte, combinational, zero added cycles.
- Write hit: byte written and dirty set at the next posedge.
- cpu_read and cpu_write both high is illegal; the block treats it as a write.
- FSM states: IDLE, WB_REQ, WB_GAP, FILL_REQ, FILL_GAP, UPDATE.
- IDLE:
  - Miss with victim valid && dirty -> WB_REQ, beat = 0.
  - Miss otherwise -> FILL_REQ, beat = 0.
- WB_REQ:
  - Drive mem_write = 1, mem_address = {victim_tag, index, beat}, mem_writedata = victim byte[beat].
  - Posedge with mem_busywait = 0 while the request is asserted = beat complete -> deassert the request, go to WB_GAP.
- WB_GAP: one cycle with no request. Then beat + 1 -> WB_REQ; if beat was 3 -> FILL_REQ with beat = 0.
- FILL_REQ:
  - Drive mem_read = 1, mem_address = {cpu_tag, index, beat}.
  - On completion capture mem_readdata into fill buffer[beat] -> FILL_GAP.
- FILL_GAP: one cycle with no request; beat + 1 -> FILL_REQ, or after beat 3 -> UPDATE.
- UPDATE: write the fill buffer into the line; tag = cpu_tag, valid = 1, dirty = 0 -> IDLE. The original request then hits in the following cycle.
- The mandatory gap guarantees the memory sees a fresh request edge for every beat.
- mem_read and mem_write are never both high.
- The CPU must hold request, address and data stable while cpu_busywait = 1. Changes mid-miss are unsupported.
- Reset (async) mid-operation:
  - FSM -> IDLE; all valid and dirty bits -> 0; beat -> 0.
  - mem_read, mem_write -> 0; mem_address, mem_writedata -> 0.
  - Any in-flight memory beat is abandoned.
  - cpu_readdata is 0 while there is no hit.
- Data array contents are not reset.

Optional Feature:
- DCACHE_STATS_EN defined: adds outputs hit_count[15:0] and miss_count[15:0].
  - Each counter increments once per request resolution: a hit in IDLE without a prior miss counts as a hit; a miss entry counts as a miss.
  - Counters saturate at 16'hFFFF and are cleared by reset.
- Not defined: no counters and no extra ports.

Decomposition:
- Shared package dcache_pkg: state enum encoding, TAG_W, IDX_W, OFF_W derived constants.
- One natural sub-module: dcache_line_array, holding the valid/dirty/tag/data storage with a combinational read port and a synchronous single-byte or whole-line write port.
- The FSM and the memory initiator stay in the top module.

Test Plan:
- Reset, then cpu_read at 0x25 -> miss; 4 fill reads of 0x24..0x27 with no write-back; cpu_readdata = mem[0x25]; stall releases after UPDATE + 1.
- Second cpu_read at 0x26 -> hit; cpu_busywait stays 0; no memory request issued.
- cpu_write 0xAB at 0x24, then cpu_read at 0xA4 (same index, new tag) -> 4 write-backs to 0x24..0x27 with byte 0 = 0xAB, then 4 fills from 0xA4..0xA7.
- Reset asserted during fill beat 2 -> mem_read = 0 immediately; next read of 0x25 misses again.
- Throughout: mem_read/mem_write drop for at least one cycle between beats and are never both high (assertion).
- DCACHE_STATS_EN defined: the sequence above (before any reset) -> hit_count = 2, miss_count = 2.
